irq_dispatch: RTL

- Sits directly downstream of the interrupt priority arbiter; consumes its winning (valid, prio, idx) triple and presents one interrupt request to the core.
- Compares the winner against the current preemption level: the maximum of the software threshold and the top of an internal nesting-level stack.
- Performs the valid/ready handshake with the core and emits a one-cycle claim pulse so upstream pending logic clears the accepted line.
- Tracks nested preemption: pushes the level on accept and pops it on mret.

---
 rtl/irq_dispatch.sv | 133 +++++++++++++
 1 files changed

// File: rtl/irq_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : irq_dispatch
// Brief   : Preemption-level gate, core handshake, claim pulse and nest stack
// Revision: 1.0
// ============================================================================
module irq_dispatch #(
  parameter int unsigned NrInputs  = 32,
  parameter int unsigned PrioWidth = 8,
  parameter int unsigned NestDepth = 4,
  localparam int unsigned IdxWidth   = $clog2(NrInputs),
  localparam int unsigned DepthWidth = $clog2(NestDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  arb_valid_i,
  input  logic [PrioWidth-1:0]  arb_prio_i,
  input  logic [IdxWidth-1:0]   arb_idx_i,
  input  logic [PrioWidth-1:0]  thresh_i,
  output logic                  irq_valid_o,
  input  logic                  irq_ready_i,
  output logic [IdxWidth-1:0]   irq_id_o,
  output logic [PrioWidth-1:0]  irq_prio_o,
  input  logic                  mret_i,
  output logic                  claim_o,
  output logic [IdxWidth-1:0]   claim_idx_o,
  output logic [PrioWidth-1:0]  level_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  err_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLAIM  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  irq_valid_q, irq_valid_d;
  logic [IdxWidth-1:0]   irq_id_q, irq_id_d;
  logic [PrioWidth-1:0]  irq_prio_q, irq_prio_d;
  logic [IdxWidth-1:0]   claim_idx_q, claim_idx_d;
  logic                  err_q, err_d;
  logic [DepthWidth-1:0] depth_q, depth_d;
  logic [PrioWidth-1:0]  stack_q [NestDepth];
  logic [PrioWidth-1:0]  stack_d [NestDepth];

  logic [PrioWidth-1:0]  w_top_prio;
  logic [PrioWidth-1:0]  w_level;
  logic                  w_eligible;
  logic                  w_handshake;
  logic                  w_pop;
  logic                  w_push;
  logic [DepthWidth-1:0] w_depth_popped;

  always_comb begin
    w_top_prio = '0;
    for (int i = 0; i < NestDepth; i++) begin
      if (depth_q == DepthWidth'(i + 1)) w_top_prio = stack_q[i];
    end
    w_level     = (thresh_i > w_top_prio) ? thresh_i : w_top_prio;
    w_eligible  = arb_valid_i && (arb_prio_i > w_level) &&
                  (depth_q < DepthWidth'(NestDepth));
    w_handshake = irq_valid_q && irq_ready_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      irq_prio_q  <= '0;
      claim_idx_q <= '0;
      err_q       <= 1'b0;
      depth_q     <= '0;
      for (int i = 0; i < NestDepth; i++) stack_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      irq_prio_q  <= irq_prio_d;
      claim_idx_q <= claim_idx_d;
      err_q       <= err_d;
      depth_q     <= depth_d;
      stack_q     <= stack_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_handshake) state_d = ST_CLAIM;
      ST_CLAIM:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    irq_valid_d = 1'b0;
    case (state_q)
      ST_IDLE:   irq_valid_d = w_eligible && !w_handshake;
      ST_SETTLE: irq_valid_d = w_eligible;
      default:   irq_valid_d = 1'b0;
    endcase
    irq_id_d    = arb_idx_i;
    irq_prio_d  = arb_prio_i;
    claim_idx_d = w_handshake ? irq_id_q : claim_idx_q;
    err_d       = mret_i && (depth_q == '0);

    // Pop before push so a same-cycle mret and accept replaces the top entry.
    w_pop          = mret_i && (depth_q != '0);
    w_depth_popped = w_pop ? (depth_q - DepthWidth'(1)) : depth_q;
    w_push         = w_handshake && (w_depth_popped < DepthWidth'(NestDepth));
    depth_d        = w_push ? (w_depth_popped + DepthWidth'(1)) : w_depth_popped;
    stack_d        = stack_q;
    for (int i = 0; i < NestDepth; i++) begin
      if (w_push && (w_depth_popped == DepthWidth'(i))) stack_d[i] = irq_prio_q;
    end
  end

  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign irq_prio_o  = irq_prio_q;
  assign claim_o     = (state_q == ST_CLAIM);
  assign claim_idx_o = claim_idx_q;
  assign level_o     = w_level;
  assign depth_o     = depth_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire
